// File: rtl/leb128_u32_arb_enc.sv
// leb128_u32_arb_enc
//   Shared LEB128 encoder front-end. Round-robin arbitration among NREQ
//   producers of unsigned 32-bit values. One value is accepted at a time,
//   packed into 1..5 LEB128 bytes, and serialized onto a single valid/ready
//   byte stream tagged with the source requester ID.
//
// Ports
//   clk        clock, all state on the rising edge
//   rst        asynchronous active-high reset
//   req_valid  per-requester value valid                     [NREQ]
//   req_data   per-requester value, requester i at [32i+:32] [32*NREQ]
//   req_ready  per-requester accept, at most one bit high    [NREQ]
//   out_valid  output byte valid
//   out_data   LEB128 byte
//   out_last   final byte of the current value
//   out_id     requester whose value is being emitted        [IDW]
//   out_ready  downstream accepts byte
//   busy       a value is held (state EMIT)
module leb128_u32_arb_enc #(
  parameter int NREQ = 4,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 out_valid,
  output logic [7:0]           out_data,
  output logic                 out_last,
  output logic [IDW-1:0]       out_id,
  input  logic                 out_ready,
  output logic                 busy
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t           state_reg;
  logic [7:0]       byte_reg [5];
  logic [2:0]       len_reg;
  logic [2:0]       idx_reg;
  logic [IDW-1:0]   id_reg;
  logic [IDW-1:0]   rr_reg;

  logic [IDW-1:0]   grant;
  logic             any_valid;
  logic             accept_win;
  logic             transfer;
  logic [31:0]      sel_data;
  logic [6:0]       chunk [5];
  logic [4:0]       chunk_nz;
  logic [7:0]       byte_next [5];
  logic [2:0]       len_next;
  logic [IDW-1:0]   rr_next;

  // Round-robin grant: scan offsets from highest to lowest so the valid
  // requester closest at-or-after the pointer is the one left standing.
  always_comb begin
    int cand;
    logic [IDW-1:0] cand_id;
    grant     = '0;
    any_valid = 1'b0;
    cand      = 0;
    cand_id   = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      cand = int'(rr_reg) + off;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_id = IDW'(cand);
      if (req_valid[cand_id]) begin
        grant     = cand_id;
        any_valid = 1'b1;
      end
    end
  end

  assign rr_next = (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;

  // Accept window also opens on the final-byte handshake so back-to-back
  // values leave no bubble. Held closed during reset.
  assign accept_win = !rst && ((state_reg == IDLE) || (out_ready && out_last));
  assign transfer   = accept_win && any_valid;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_ready
      assign req_ready[gi] = transfer && (grant == IDW'(gi));
    end
  endgenerate

  // Packer works only on the granted value; req_data of other requesters
  // never reaches the output path.
  assign sel_data = req_data[32*grant +: 32];

  generate
    for (gi = 0; gi < 5; gi++) begin : g_chunk
      if (gi < 4) begin : g_low
        assign chunk[gi] = sel_data[7*gi +: 7];
      end else begin : g_top
        assign chunk[gi] = {3'b000, sel_data[31:28]};
      end
      assign chunk_nz[gi]  = |chunk[gi];
      // Continuation bit set on every byte except the last one.
      assign byte_next[gi] = {(3'(gi) < (len_next - 3'd1)), chunk[gi]};
    end
  endgenerate

  always_comb begin
    len_next = 3'd1;
    if      (chunk_nz[4]) len_next = 3'd5;
    else if (chunk_nz[3]) len_next = 3'd4;
    else if (chunk_nz[2]) len_next = 3'd3;
    else if (chunk_nz[1]) len_next = 3'd2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      len_reg   <= 3'd0;
      idx_reg   <= 3'd0;
      id_reg    <= '0;
      rr_reg    <= '0;
      for (int k = 0; k < 5; k++) byte_reg[k] <= 8'h00;
    end else begin
      if (transfer) begin
        for (int k = 0; k < 5; k++) byte_reg[k] <= byte_next[k];
        len_reg   <= len_next;
        idx_reg   <= 3'd0;
        id_reg    <= grant;
        rr_reg    <= rr_next;
        state_reg <= EMIT;
      end else if (state_reg == EMIT && out_ready) begin
        if (out_last) state_reg <= IDLE;
        else          idx_reg   <= idx_reg + 3'd1;
      end
    end
  end

  // Outputs decode directly from registers; forced to zero in IDLE.
  assign busy      = (state_reg == EMIT);
  assign out_valid = busy;
  assign out_data  = busy ? byte_reg[idx_reg] : 8'h00;
  assign out_last  = busy && (idx_reg == len_reg - 3'd1);
  assign out_id    = busy ? id_reg : '0;

endmodule

// File: tb/tb_leb128_u32_arb_enc.sv
module tb_leb128_u32_arb_enc;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [32*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  logic [7:0]        out_data;
  logic              out_last;
  logic [IDW-1:0]    out_id;
  logic              out_ready;
  logic              busy;

  int n_cmp = 0;
  int n_err = 0;

  leb128_u32_arb_enc #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_id    (out_id),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'hF; req_data = '0; out_ready = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
    n_cmp++; if (out_id !== 2'd0) begin n_err++; $display("FAIL reset_out_id got=%0d exp=0", out_id); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy_after_edge got=%b exp=0", busy); end
    @(negedge clk);
    req_valid = 4'h0; rst = 1'b0;
    $display("reset: done");
  endtask

  task automatic test_pack();
    logic [31:0] pv [7];
    int          pr [7];
    int          pl [7];
    logic [7:0]  pb [7][5];
    pv = '{32'h0, 32'h00098765, 32'hFFFFFFFF, 32'd127, 32'd128, 32'h10000000, 32'h12345678};
    pr = '{0, 2, 1, 3, 0, 2, 1};
    pl = '{1, 3, 5, 1, 2, 5, 5};
    pb[0] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    pb[1] = '{8'hE5, 8'h8E, 8'h26, 8'h00, 8'h00};
    pb[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F};
    pb[3] = '{8'h7F, 8'h00, 8'h00, 8'h00, 8'h00};
    pb[4] = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00};
    pb[5] = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h01};
    pb[6] = '{8'hF8, 8'hAC, 8'hD1, 8'h91, 8'h01};
    for (int v = 0; v < 7; v++) begin
      @(negedge clk);
      req_valid = '0; req_valid[pr[v]] = 1'b1;
      req_data[32*pr[v] +: 32] = pv[v];
      out_ready = 1'b1;
      #1;
      n_cmp++; if (req_ready !== 4'(1 << pr[v])) begin n_err++; $display("FAIL pack_req_ready v=%h got=%b exp=%b", pv[v], req_ready, 4'(1 << pr[v])); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL pack_idle_before v=%h got=%b exp=0", pv[v], out_valid); end
      for (int k = 0; k < pl[v]; k++) begin
        @(negedge clk);
        req_valid = '0;
        #1;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL pack_valid v=%h k=%0d got=%b exp=1", pv[v], k, out_valid); end
        n_cmp++; if (out_data !== pb[v][k]) begin n_err++; $display("FAIL pack_data v=%h k=%0d got=%h exp=%h", pv[v], k, out_data, pb[v][k]); end
        n_cmp++; if (out_last !== (k == pl[v] - 1)) begin n_err++; $display("FAIL pack_last v=%h k=%0d got=%b exp=%b", pv[v], k, out_last, (k == pl[v] - 1)); end
        n_cmp++; if (out_id !== 2'(pr[v])) begin n_err++; $display("FAIL pack_id v=%h k=%0d got=%0d exp=%0d", pv[v], k, out_id, pr[v]); end
      end
      @(negedge clk); #1;
      n_cmp++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin n_err++; $display("FAIL pack_idle_after v=%h valid=%b data=%h exp valid=0 data=00", pv[v], out_valid, out_data); end
      $display("pack: req=%0d value=%h len=%0d", pr[v], pv[v], pl[v]);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] eb [7];
    int         ei [7];
    logic       el [7];
    logic [3:0] exp_rdy;
    eb = '{8'h01, 8'hC8, 8'h01, 8'h05, 8'h80, 8'h80, 8'h01};
    ei = '{0, 1, 1, 2, 3, 3, 3};
    el = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    // Reset first so the pointer is known to restart at requester 0.
    @(negedge clk); rst = 1'b1; req_valid = '0;
    @(negedge clk); rst = 1'b0;
    req_data = {32'h00004000, 32'd5, 32'd200, 32'd1};
    req_valid = 4'hF; out_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL b2b_first_grant got=%b exp=0001", req_ready); end
    for (int c = 0; c < 14; c++) begin
      int j;
      j = c % 7;
      exp_rdy = el[j] ? 4'(1 << ((ei[j] + 1) % 4)) : 4'b0000;
      @(negedge clk); #1;
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid c=%0d got=%b exp=1", c, out_valid); end
      n_cmp++; if (out_data !== eb[j]) begin n_err++; $display("FAIL b2b_data c=%0d got=%h exp=%h", c, out_data, eb[j]); end
      n_cmp++; if (out_id !== 2'(ei[j])) begin n_err++; $display("FAIL b2b_id c=%0d got=%0d exp=%0d", c, out_id, ei[j]); end
      n_cmp++; if (out_last !== el[j]) begin n_err++; $display("FAIL b2b_last c=%0d got=%b exp=%b", c, out_last, el[j]); end
      n_cmp++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL b2b_req_ready c=%0d got=%b exp=%b", c, req_ready, exp_rdy); end
      if (el[j]) $display("b2b: value from req=%0d done", ei[j]);
    end
    @(negedge clk); req_valid = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_stall();
    logic [7:0] eb [5];
    int         hs;
    logic       prev_stall;
    logic [7:0] prev_data;
    eb = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F};
    hs = 0; prev_stall = 1'b0; prev_data = 8'h00;
    @(negedge clk);
    req_valid = 4'b0010; req_data[63:32] = 32'hFFFFFFFF; out_ready = 1'b1;
    for (int c = 0; c < 200 && hs < 5; c++) begin
      @(negedge clk);
      req_valid = '0;
      req_data  = {$urandom, $urandom, $urandom, $urandom};
      out_ready = 1'($urandom_range(0, 1));
      #1;
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid c=%0d got=%b exp=1", c, out_valid); end
      n_cmp++; if (out_data !== eb[hs] || out_last !== (hs == 4) || out_id !== 2'd1) begin
        n_err++; $display("FAIL stall_byte hs=%0d data=%h last=%b id=%0d exp data=%h last=%b id=1", hs, out_data, out_last, out_id, eb[hs], (hs == 4));
      end
      if (prev_stall) begin
        n_cmp++; if (out_data !== prev_data) begin n_err++; $display("FAIL stall_hold got=%h exp=%h", out_data, prev_data); end
      end
      prev_stall = !out_ready;
      prev_data  = out_data;
      if (out_valid && out_ready) hs++;
    end
    n_cmp++; if (hs !== 5) begin n_err++; $display("FAIL stall_handshakes got=%0d exp=5", hs); end
    @(negedge clk); out_ready = 1'b1; #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stall_idle_after got=%b exp=0", out_valid); end
    $display("stall: 0xFFFFFFFF handshakes=%0d", hs);
  endtask

  task automatic test_reset_mid();
    int nl;
    @(negedge clk);
    req_valid = 4'b0010; req_data[63:32] = 32'h12345678; out_ready = 1'b1;
    @(negedge clk); req_valid = '0; #1;
    n_cmp++; if (out_data !== 8'hF8) begin n_err++; $display("FAIL mid_b0 got=%h exp=F8", out_data); end
    @(negedge clk); #1;
    n_cmp++; if (out_data !== 8'hAC) begin n_err++; $display("FAIL mid_b1 got=%h exp=AC", out_data); end
    @(negedge clk); out_ready = 1'b0; #1;
    n_cmp++; if (out_data !== 8'hD1 || out_valid !== 1'b1) begin n_err++; $display("FAIL mid_b2 data=%h valid=%b exp D1/1", out_data, out_valid); end
    @(posedge clk); #1;
    n_cmp++; if (out_data !== 8'hD1) begin n_err++; $display("FAIL mid_b2_hold got=%h exp=D1", out_data); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0 || out_id !== 2'd0 || busy !== 1'b0) begin
      n_err++; $display("FAIL mid_async_reset valid=%b data=%h last=%b id=%0d busy=%b exp all 0", out_valid, out_data, out_last, out_id, busy);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0; out_ready = 1'b1; #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_no_more_bytes got=%b exp=0", out_valid); end
    req_valid = 4'b1000; req_data[127:96] = 32'd5; #1;
    n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL mid_sole_grant got=%b exp=1000", req_ready); end
    @(negedge clk); req_valid = '0; #1;
    n_cmp++; if (out_valid !== 1'b1 || out_id !== 2'd3 || out_data !== 8'h05 || out_last !== 1'b1) begin
      n_err++; $display("FAIL mid_sole_byte valid=%b id=%0d data=%h last=%b exp 1/3/05/1", out_valid, out_id, out_data, out_last);
    end
    @(negedge clk);
    req_data = {32'd7, 32'd5, 32'd200, 32'd1};
    req_valid = 4'hF; #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL mid_resume_grant got=%b exp=0001", req_ready); end
    nl = 0;
    for (int c = 0; c < 10 && nl < 3; c++) begin
      @(negedge clk); #1;
      if (out_valid && out_last) begin
        n_cmp++; if (out_id !== 2'(nl)) begin n_err++; $display("FAIL mid_order n=%0d got=%0d exp=%0d", nl, out_id, nl); end
        $display("resume: value from req=%0d done", out_id);
        nl++;
      end
    end
    n_cmp++; if (nl !== 3) begin n_err++; $display("FAIL mid_order_timeout got=%0d exp=3", nl); end
    @(negedge clk); req_valid = '0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_pack();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/leb128_u32_arb_enc.md
# leb128_u32_arb_enc

Shared LEB128 encoder front-end: arbitrates round-robin among NREQ producers of unsigned 32-bit values, accepts one value at a time, packs it into 1–5 LEB128 bytes, and serializes the bytes onto a single valid/ready byte stream tagged with the source requester ID. It sits between value-producing units and the byte-oriented output path, so that one packer and one output port serve all producers.

## Interface
- NREQ, 4, number of requesters (legal 1..8)
- IDW, $clog2(NREQ) (min 1), width of requester ID
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester value valid
- req_data  in  32*NREQ  per-requester value; requester i at bits [32i+31:32i]
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle
- out_valid  out  1  output byte valid
- out_data  out  8  LEB128 byte
- out_last  out  1  final byte of the current value
- out_id  out  IDW  requester whose value is being emitted
- out_ready  in  1  downstream accepts byte
- busy  out  1  a value is held (state EMIT)

## Operation
- Packing: chunk c_k = value[7k+6:7k] for k=0..3; c4 = {3'b000, value[31:28]}. len = 1 + index of highest nonzero chunk (len=1 for value 0, max 5). Byte k = {k < len-1, c_k}, for k = 0..len-1.
- States: IDLE, EMIT. Registers: byte buffer (5x8), len (3b), idx (3b), id (IDW), rr pointer (IDW).
- Arbitration: candidates are requesters with req_valid=1; grant goes to the first valid index at or after rr pointer, wrapping modulo NREQ. Grant is computed combinationally.
- Accept window: state IDLE, or state EMIT with out_valid & out_ready & out_last (back-to-back). In the window, req_ready[grant]=1 if any req_valid; a value transfers on req_valid[g] & req_ready[g].
- On transfer: latch the packed bytes, len, and id=g; set idx=0; set rr = (g+1) mod NREQ; state becomes EMIT.
- EMIT: out_valid=1, out_data=byte[idx], out_last=(idx==len-1), out_id=id. On out_ready with !out_last, idx increments. On out_ready with out_last, state becomes EMIT if a transfer occurs in the same cycle, else IDLE.
- In IDLE: out_valid=0, and out_data, out_last and out_id are driven 0.
- busy = (state==EMIT).
- rr advances only on a transfer, never on idle cycles.

## Timing
- Reset values: state IDLE, out_valid 0, out_data 0x00, out_last 0, out_id 0, busy 0, req_ready all 0 while rst high, rr 0, idx 0, len 0.
- Reset mid-emission: the value is dropped immediately; no further bytes; the first grant after reset starts from requester 0.
- Latency: value accepted in cycle N, so first byte is valid in cycle N+1. A value of len L with out_ready held high occupies L cycles.
- Throughput: back-to-back values produce no bubble; sustained rate is 1 byte/cycle.
- req_ready has a combinational path from out_ready in EMIT; it has no path from req_data.
- Hold rule: while out_valid & !out_ready, out_data, out_last and out_id are stable. Changes to req_* have no effect on them.
- A requester may drop req_valid without a transfer; no state change results.
- NREQ=1: the pointer is constant 0 and the arbitration is trivial; behaviour is otherwise identical.

## Test plan
- Requester 0 sends 0, out_ready=1: one byte 0x00 with out_last=1 and out_id=0, in the cycle after the transfer; then IDLE.
- Requester 2 sends 624485 (0x98765): bytes E5, 8E, 26 in consecutive cycles; out_last only on 0x26; out_id=2.
- Sends 0xFFFFFFFF: bytes FF FF FF FF 0F; 127: 7F; 128: 80 01; 0x10000000: 80 80 80 80 01.
- All four requesters valid continuously with distinct values, out_ready=1: grant order 0,1,2,3,0,…; req_ready pulses coincide with each out_last handshake; no idle cycle between values.
- Random out_ready (~50%) on 0xFFFFFFFF: byte sequence unchanged; output stable while stalled; exactly 5 handshakes.
- Assert rst while the 3rd of 5 bytes is stalled: outputs go to reset values asynchronously; after release, requester 3 valid alone is granted; then with all requesters valid, order resumes from rr = 0 (3 then 0,1,2 — rr=0 after reset, so requester 3 granted only if it is the sole valid one).
